window_generator: RTL and testbench
===================================

// Module: window_generator
// PURPOSE
//  Upstream stage of edge_detection: converts a raster-order 8-bit pixel stream into
//  3x3 neighbourhoods P0..P8 using two line buffers. Issues a one-cycle gradient start
//  per interior window, then stalls the stream until edge_detection reports its result.
//  Window layout: P0..P2 = top row (L..R), P3..P5 = middle row (P4 = centre), P6..P8 = bottom row.
// PARAMETERS
//  IMG_WIDTH   640  pixels per row; legal range >= 3
//  IMG_HEIGHT  480  rows per frame; legal range >= 3
// PORTS
//  clk                     in   1  system clock, rising edge
//  n_rst                   in   1  asynchronous, active-low reset
//  i_pixel_valid           in   1  i_pixel holds a valid pixel
//  i_pixel                 in   8  pixel value, raster order, row 0 col 0 first
//  o_pixel_ready           out  1  pixel consumed at posedge when valid && ready
//  i_gradient_data_ready   in   1  edge_detection o_gradient_data_ready
//  o_gradient_start        out  1  one-cycle pulse: P0..P8 hold a new window
//  P0..P8                  out  8 each  3x3 window to edge_detection
//  o_frame_done            out  1  one-cycle pulse with the last window of a frame
// BEHAVIOUR
//  - Reset values: P0..P8 = 0, o_gradient_start = 0, o_pixel_ready = 0, o_frame_done = 0.
//    Row and column counters reset to 0, and state resets to IDLE.
//  - Line buffer contents are not reset. They are never exposed before two full rows are written.
//  - FSM states: IDLE -> ACCEPT (unconditional, 1 cycle after reset release).
//    ACCEPT: o_pixel_ready = 1.
//    On accept at (row>=2, col>=2): go to START, and drive o_pixel_ready = 0 from the next cycle.
//    START: o_gradient_start = 1 for exactly one cycle, then go to WAIT.
//    WAIT: o_pixel_ready = 0. Return to ACCEPT on a rising edge of i_gradient_data_ready
//    (registered previous value = 0, current = 1). A level held high does not release WAIT.
//  - On accept of pixel p at column c:
//    top = lb2[c], mid = lb1[c], bot = p.
//    Window shifts one column left; new right column = {top, mid, bot} -> P2/P5/P8.
//    Then lb2[c] <= lb1[c] and lb1[c] <= p.
//  - Latency: the accept edge at an interior position loads P0..P8. o_gradient_start is high
//    during the following cycle. P0..P8 are stable from that cycle until the next accept.
//  - Accepts at row<2 or col<2 update buffers, window and counters with no start.
//    These accepts run back-to-back at 1 pixel/cycle.
//  - i_pixel_valid = 0, or valid while ready = 0: no state, counter or buffer change.
//    The source holds the pixel.
//  - Counters: col wraps IMG_WIDTH-1 -> 0 and increments row. Row wraps IMG_HEIGHT-1 -> 0 at end of frame.
//    Widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).
//  - Windows per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//  - o_frame_done: pulses in the same cycle as the start for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
//  - The first two rows of each new frame produce no starts. Stale previous-frame data is never windowed.
//  - Async reset in any state, including WAIT: all outputs and counters return to reset values
//    immediately. The next accepted pixel is row 0, col 0.
// STRUCTURE
//  - Shared package edge_pkg:
//    typedef logic [7:0] pixel_t; typedef enum {IDLE, ACCEPT, START, WAIT} win_state_t.
//  - Sub-module line_buffer (x2): IMG_WIDTH x pixel_t array, one read and one write
//    at the same column address per accept. Read returns the old contents.
//  - Top level holds: the FSM, row/col counters, 3x3 window registers, and the
//    i_gradient_data_ready edge-detect flop.
// TESTING (bench: IMG_WIDTH=5, IMG_HEIGHT=4, pixel = 10*row+col, edge_detection model
//  pulses ready 18 cycles after each start)
//  1 Reset: hold n_rst=0 -> all outputs 0. Release -> o_pixel_ready=1 on the second posedge.
//  2 Full frame, valid always high -> exactly 6 starts.
//    First window: P0..P8 = 0,1,2,10,11,12,20,21,22.
//    Last window: 12,13,14,22,23,24,32,33,34, with o_frame_done=1.
//  3 Backpressure: in WAIT, offer pixel 99 -> ready=0, P0..P8 unchanged, 99 not consumed.
//    Pixel 99 is accepted on the first ACCEPT cycle after the ready rising edge.
//  4 Hold i_gradient_data_ready=1 continuously -> only one window is released.
//    The second window follows only after ready drops and rises again.
//  5 Valid gaps: insert 3 idle cycles between every pixel of frame 2.
//    Window values are identical to test 2, with no starts during rows 0-1 of frame 2.
//  6 Assert n_rst in WAIT after window 3 -> start=0 and P=0 at once.
//    A new frame from row 0 yields 6 windows matching test 2.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types for the edge-detection pipeline: pixel type, window size and
// the window generator's FSM states.
package edge_pkg;

    typedef logic [7:0] pixel_t;

    // Window generator FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        START  = 2'd2,
        WAIT   = 2'd3
    } win_state_t;

    // Number of taps in a 3x3 neighbourhood.
    localparam int WIN_TAPS = 9;

endpackage

// File: rtl/window_generator_line_buffer.sv
// One row of pixel storage. Read and write share the column address; the read
// returns the contents from before this cycle's write, so a single buffer can
// hand out the previous row while being overwritten with the current one.
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wr_data,
    output logic [7:0]        o_rd_data
);
    import edge_pkg::*;

    // Contents are deliberately not reset: nothing reads a row before it has
    // been written in the current frame.
    pixel_t mem_q [DEPTH];

    assign o_rd_data = mem_q[i_addr];

    // Write the new pixel into its column on every accept.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_addr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/window_generator.sv
// Converts a raster-order pixel stream into 3x3 windows for edge_detection.
// Two line buffers supply the two rows above the incoming pixel. Each interior
// pixel produces one gradient start, after which the stream is stalled until
// edge_detection signals completion with a rising edge on its ready line.
//
// Handshake: a pixel is consumed on a rising clk edge where
// i_pixel_valid && o_pixel_ready; the source must hold i_pixel stable while
// valid is high and ready is low.
module window_generator #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_pixel_valid,
    input  logic [7:0] i_pixel,
    output logic       o_pixel_ready,
    input  logic       i_gradient_data_ready,
    output logic       o_gradient_start,
    output logic [7:0] P0,
    output logic [7:0] P1,
    output logic [7:0] P2,
    output logic [7:0] P3,
    output logic [7:0] P4,
    output logic [7:0] P5,
    output logic [7:0] P6,
    output logic [7:0] P7,
    output logic [7:0] P8,
    output logic       o_frame_done,
    output logic [1:0] o_dbg_state
);
    import edge_pkg::*;

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    win_state_t       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    pixel_t           win_q [WIN_TAPS];
    pixel_t           win_d [WIN_TAPS];
    logic             frame_done_q, frame_done_d;
    logic             grad_rdy_prev_q, grad_rdy_prev_d;

    logic   accept;
    logic   interior;
    logic   last_pixel;
    logic   grad_rise;
    pixel_t lb1_rd;
    pixel_t lb2_rd;

    assign accept     = i_pixel_valid && (state_q == ACCEPT);
    // A full 3x3 neighbourhood exists once two rows and two columns precede us.
    assign interior   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // Only a 0->1 transition releases WAIT; a level held high does not.
    assign grad_rise  = i_gradient_data_ready && !grad_rdy_prev_q;

    // lb1 holds row r-1, lb2 holds row r-2; lb2 is refilled from lb1's old data.
    line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
        .clk       (clk),
        .i_wr_en   (accept),
        .i_addr    (col_q),
        .i_wr_data (i_pixel),
        .o_rd_data (lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb2 (
        .clk       (clk),
        .i_wr_en   (accept),
        .i_addr    (col_q),
        .i_wr_data (lb1_rd),
        .o_rd_data (lb2_rd)
    );

    // FSM: accept pixels, pulse start after an interior accept, then stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ACCEPT;
            ACCEPT:  if (accept && interior) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (grad_rise) state_d = ACCEPT;
            default: state_d = IDLE;
        endcase
    end

    // Counters, window shift and frame-done flag, all advanced only on accept.
    always_comb begin
        col_d           = col_q;
        row_d           = row_q;
        win_d           = win_q;
        frame_done_d    = 1'b0;
        grad_rdy_prev_d = i_gradient_data_ready;
        if (accept) begin
            // Shift left by one column; new right column is {top, mid, bottom}.
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb2_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb1_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = i_pixel;
            frame_done_d = interior && last_pixel;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            col_q           <= '0;
            row_q           <= '0;
            frame_done_q    <= 1'b0;
            grad_rdy_prev_q <= 1'b0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            frame_done_q    <= frame_done_d;
            grad_rdy_prev_q <= grad_rdy_prev_d;
            win_q           <= win_d;
        end
    end

    assign o_pixel_ready    = (state_q == ACCEPT);
    assign o_gradient_start = (state_q == START);
    assign o_frame_done     = frame_done_q;
    assign o_dbg_state      = state_q;

    assign P0 = win_q[0];
    assign P1 = win_q[1];
    assign P2 = win_q[2];
    assign P3 = win_q[3];
    assign P4 = win_q[4];
    assign P5 = win_q[5];
    assign P6 = win_q[6];
    assign P7 = win_q[7];
    assign P8 = win_q[8];

endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator on a 5x4 image with pixel = 10*row + col.
// The reference model stores the accepted image and builds each expected
// window directly from the row/column neighbourhood rule.
module tb_window_generator;

    localparam int W          = 5;
    localparam int H          = 4;
    localparam int GRAD_DELAY = 18;
    localparam int TIMEOUT    = 300;

    localparam logic [71:0] WIN_FIRST = {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
    localparam logic [71:0] WIN_LAST  = {8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34};
    localparam logic [71:0] WIN_99    = {8'd1, 8'd2, 8'd3, 8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd99};

    // ---------------- clock / reset / DUT ----------------
    logic       clk;
    logic       n_rst;
    logic       i_pixel_valid;
    logic [7:0] i_pixel;
    logic       o_pixel_ready;
    logic       i_gradient_data_ready;
    logic       o_gradient_start;
    logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
    logic       o_frame_done;
    logic [1:0] o_dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .i_pixel_valid         (i_pixel_valid),
        .i_pixel               (i_pixel),
        .o_pixel_ready         (o_pixel_ready),
        .i_gradient_data_ready (i_gradient_data_ready),
        .o_gradient_start      (o_gradient_start),
        .P0                    (P0),
        .P1                    (P1),
        .P2                    (P2),
        .P3                    (P3),
        .P4                    (P4),
        .P5                    (P5),
        .P6                    (P6),
        .P7                    (P7),
        .P8                    (P8),
        .o_frame_done          (o_frame_done),
        .o_dbg_state           (o_dbg_state)
    );

    logic [71:0] dut_p;
    assign dut_p = {P0, P1, P2, P3, P4, P5, P6, P7, P8};

    // ---------------- scoreboard state ----------------
    int          checks;
    int          errors;
    logic [72:0] exp_q[$];   // {window, frame_done} expected per start
    logic [72:0] seen_q[$];  // {window, frame_done} observed per start
    logic [7:0]  img [H][W];
    int          m_idx;
    logic        win_hold;
    logic [71:0] last_win;
    int          start_count;
    logic        abort;

    // gradient-ready source: automatic edge_detection model or manual control
    logic auto_mode;
    logic auto_rdy;
    logic manual_rdy;
    int   grad_cnt;
    assign i_gradient_data_ready = auto_mode ? auto_rdy : manual_rdy;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        exp_q.delete();
        m_idx    = 0;
        win_hold = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] p);
        int r;
        int c;
        logic [71:0] w;
        r = m_idx / W;
        c = m_idx % W;
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
            w = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    w = {w[63:0], img[r-2+i][c-2+j]};
                end
            end
            exp_q.push_back({w, (r == H - 1) && (c == W - 1)});
        end
        win_hold = 1'b0;
        m_idx = (m_idx + 1) % (W * H);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [72:0] e;
        if (n_rst) begin
            if (o_gradient_start) begin
                start_count++;
                seen_q.push_back({dut_p, o_frame_done});
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start window=%h frame_done=%b required=no start",
                             dut_p, o_frame_done);
                end else begin
                    e = exp_q.pop_front();
                    check("window", {dut_p, o_frame_done}, e);
                    last_win = e[72:1];
                end
                check("ready_low_during_start", 73'(o_pixel_ready), 73'(0));
                win_hold = 1'b1;
            end else begin
                check("frame_done_without_start", 73'(o_frame_done), 73'(0));
                if (win_hold) check("window_hold", 73'(dut_p), 73'(last_win));
            end
        end
    end

    // ---------------- edge_detection model: ready pulse 18 cycles after start ----------------
    always @(negedge clk) begin
        if (!n_rst) begin
            grad_cnt = 0;
            auto_rdy = 1'b0;
        end else begin
            if (grad_cnt > 0) begin
                grad_cnt--;
                auto_rdy = (grad_cnt == 0);
            end else begin
                auto_rdy = 1'b0;
            end
            if (o_gradient_start) grad_cnt = GRAD_DELAY;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pixel(input logic [7:0] p, input int gap);
        int n;
        n = 0;
        i_pixel_valid = 1'b1;
        i_pixel       = p;
        while (!o_pixel_ready && !abort && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (abort) begin
            i_pixel_valid = 1'b0;
            return;
        end
        if (!o_pixel_ready) begin
            checks++;
            errors++;
            $display("FAIL pixel_accept_timeout ready=0 required=1 pixel=%0d", p);
        end else begin
            @(posedge clk);
            model_accept(p);
            @(negedge clk);
        end
        if (gap > 0) begin
            i_pixel_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int gap, input int sub_idx, input logic [7:0] sub_val);
        int fbase;
        logic [7:0] p;
        fbase = start_count;
        for (int i = 0; i < W * H && !abort; i++) begin
            if (i == 2 * W) check("no_start_rows_0_1", 73'(start_count - fbase), 73'(0));
            p = 8'((i / W) * 10 + (i % W));
            if (i == sub_idx) p = sub_val;
            send_pixel(p, gap);
        end
        i_pixel_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target, input string name);
        int n;
        n = 0;
        while (start_count < target && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (start_count < target) begin
            errors++;
            $display("FAIL %s start_count=%0d required=%0d", name, start_count, target);
        end
    endtask

    task automatic check_full_frame(input string name, input int base, input int sbase);
        check({name, "_count"}, 73'(start_count - base), 73'(6));
        check({name, "_first"}, seen_q[sbase], {WIN_FIRST, 1'b0});
        check({name, "_last"}, seen_q[sbase + 5], {WIN_LAST, 1'b1});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int sbase;
        checks        = 0;
        errors        = 0;
        start_count   = 0;
        abort         = 1'b0;
        auto_mode     = 1'b1;
        manual_rdy    = 1'b0;
        last_win      = '0;
        i_pixel_valid = 1'b0;
        i_pixel       = '0;
        n_rst         = 1'b0;
        model_reset();

        // Test 1: reset values and ready timing after release
        repeat (3) @(negedge clk);
        check("rst_ready", 73'(o_pixel_ready), 73'(0));
        check("rst_start", 73'(o_gradient_start), 73'(0));
        check("rst_frame_done", 73'(o_frame_done), 73'(0));
        check("rst_window", 73'(dut_p), 73'(0));
        n_rst = 1'b1;
        #1;
        check("ready_before_first_posedge", 73'(o_pixel_ready), 73'(0));
        @(negedge clk);
        check("ready_for_second_posedge", 73'(o_pixel_ready), 73'(1));

        // Test 2: full frame, valid always high
        base  = start_count;
        sbase = seen_q.size();
        send_frame(0, -1, 8'd0);
        wait_starts(base + 6, "t2_starts");
        repeat (GRAD_DELAY + 4) @(negedge clk);
        check_full_frame("t2", base, sbase);
        check("t2_queue_empty", 73'(exp_q.size()), 73'(0));

        // Test 5: frame 2 with three idle cycles between pixels
        base  = start_count;
        sbase = seen_q.size();
        send_frame(3, -1, 8'd0);
        wait_starts(base + 6, "t5_starts");
        repeat (GRAD_DELAY + 4) @(negedge clk);
        check_full_frame("t5", base, sbase);
        check("t5_queue_empty", 73'(exp_q.size()), 73'(0));

        // Test 3: pixel 99 offered during WAIT is held until release
        auto_mode  = 1'b0;
        manual_rdy = 1'b0;
        base  = start_count;
        sbase = seen_q.size();
        fork
            send_frame(0, 13, 8'd99);
            begin
                wait_starts(base + 1, "t3_first_start");
                repeat (2) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    check("t3_stall_ready", 73'(o_pixel_ready), 73'(0));
                    @(negedge clk);
                end
                check("t3_99_not_consumed", 73'(m_idx), 73'(13));
                manual_rdy = 1'b1;
                @(negedge clk);
                check("t3_ready_after_rise", 73'(o_pixel_ready), 73'(1));
                manual_rdy = 1'b0;
                @(negedge clk);
                check("t3_99_consumed", 73'(m_idx), 73'(14));
                for (int k = 2; k <= 6; k++) begin
                    wait_starts(base + k, "t3_starts");
                    repeat (3) @(negedge clk);
                    manual_rdy = 1'b1;
                    @(negedge clk);
                    manual_rdy = 1'b0;
                end
            end
        join
        repeat (3) @(negedge clk);
        check("t3_count", 73'(start_count - base), 73'(6));
        check("t3_window_with_99", seen_q[sbase + 1], {WIN_99, 1'b0});
        check("t3_queue_empty", 73'(exp_q.size()), 73'(0));

        // Test 4: a held-high ready level releases nothing; each release needs a new rise
        manual_rdy = 1'b1;
        base = start_count;
        fork
            send_frame(0, -1, 8'd0);
            begin
                for (int k = 1; k <= 6; k++) begin
                    wait_starts(base + k, "t4_starts");
                    if (k <= 2) begin
                        repeat (30) @(negedge clk);
                        check("t4_level_no_release", 73'(start_count - base), 73'(k));
                        check("t4_stalled_ready", 73'(o_pixel_ready), 73'(0));
                    end else begin
                        repeat (3) @(negedge clk);
                    end
                    manual_rdy = 1'b0;
                    @(negedge clk);
                    manual_rdy = 1'b1;
                end
            end
        join
        repeat (3) @(negedge clk);
        check("t4_count", 73'(start_count - base), 73'(6));
        check("t4_queue_empty", 73'(exp_q.size()), 73'(0));

        // Test 6: reset while in WAIT after window 3, then a clean frame
        auto_mode = 1'b1;
        base = start_count;
        fork
            send_frame(0, -1, 8'd0);
            begin
                wait_starts(base + 3, "t6_pre_reset_starts");
                repeat (3) @(negedge clk);
                abort = 1'b1;
                n_rst = 1'b0;
                model_reset();
                #1;
                check("t6_rst_start", 73'(o_gradient_start), 73'(0));
                check("t6_rst_window", 73'(dut_p), 73'(0));
                check("t6_rst_ready", 73'(o_pixel_ready), 73'(0));
                check("t6_rst_frame_done", 73'(o_frame_done), 73'(0));
                repeat (2) @(negedge clk);
                n_rst = 1'b1;
            end
        join
        abort = 1'b0;
        @(negedge clk);
        base  = start_count;
        sbase = seen_q.size();
        send_frame(0, -1, 8'd0);
        wait_starts(base + 6, "t6_starts");
        repeat (GRAD_DELAY + 4) @(negedge clk);
        check_full_frame("t6", base, sbase);
        check("t6_queue_empty", 73'(exp_q.size()), 73'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
